// File: rtl/ofifo_hs.sv
// Column-parallel output FIFO: one circular buffer per column with its own write
// strobe; rows drain only when every column holds data, through a registered valid/ready stage.
module ofifo_hs_col #(
  parameter int DW    = 16,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     wr_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          we;

  assign count_o = wptr_q - rptr_q;
  assign full_o  = (count_o == PW'(DEPTH));
  assign empty_o = (count_o == '0);
  assign we      = wr_i && !full_o && !clr;
  // A write to a full column is dropped even if the same edge pops it.
  assign drop_o  = wr_i && full_o && !clr;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (we)    wptr_d = wptr_q + 1'b1;
      if (pop_i) rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

module ofifo_hs #(
  parameter int col      = 8,
  parameter int psum_bw  = 16,
  parameter int depth    = 64,
  parameter int afull_th = 60
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic [psum_bw*col-1:0]   in,
  input  logic [col-1:0]           wr,
  input  logic                     rd,
  output logic [psum_bw*col-1:0]   out,
  output logic                     o_valid,
  output logic                     o_ready,
  output logic                     o_full,
  output logic                     o_almost_full,
  output logic [$clog2(depth):0]   o_level,
  output logic                     o_overflow
);
  localparam int PW = $clog2(depth) + 1;

  logic [col-1:0]               full, empty, drop;
  logic [col-1:0][PW-1:0]       cnt;
  logic [col-1:0][psum_bw-1:0]  rdata;
  logic                         row_avail, load;
  logic [psum_bw*col-1:0]       out_q, out_d;
  logic                         valid_q, valid_d, ovf_q, ovf_d;

  for (genvar g = 0; g < col; g++) begin : g_col
    ofifo_hs_col #(.DW(psum_bw), .DEPTH(depth)) u_col (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .wdata_i (in[g*psum_bw +: psum_bw]),
      .wr_i    (wr[g]),
      .pop_i   (load),
      .rdata_o (rdata[g]),
      .count_o (cnt[g]),
      .full_o  (full[g]),
      .empty_o (empty[g]),
      .drop_o  (drop[g])
    );
  end

  assign row_avail = ~|empty;
  assign load      = row_avail && (!valid_q || rd) && !clr;

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    ovf_d   = ovf_q | (|drop);
    if (clr) begin
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (load) begin
      out_d   = rdata;
      valid_d = 1'b1;
    end else if (rd) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // Level counts complete rows, i.e. the shallowest column.
  always_comb begin
    o_level       = PW'(depth);
    o_almost_full = 1'b0;
    for (int i = 0; i < col; i++) begin
      if (cnt[i] < o_level)            o_level       = cnt[i];
      if (cnt[i] >= PW'(afull_th))     o_almost_full = 1'b1;
    end
  end

  assign o_full     = |full;
  assign o_ready    = !o_full;
  assign out        = out_q;
  assign o_valid    = valid_q;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_ofifo_hs.sv
// Randomized bench for ofifo_hs against a per-column queue model of the row FIFO.
module tb_ofifo_hs;
  localparam int COL = 8, PB = 16, DEP = 64, ATH = 60;
  localparam int W = COL*PB, LW = $clog2(DEP) + 1;

  logic clk = 0, reset = 1, clr = 0, rd = 0;
  logic [W-1:0] in = '0;
  logic [COL-1:0] wr = '0;
  logic [W-1:0] out;
  logic o_valid, o_ready, o_full, o_almost_full, o_overflow;
  logic [LW-1:0] o_level;

  int n_chk = 0, n_fail = 0;

  logic [PB-1:0] mq [COL][$];
  logic [W-1:0]  m_out;
  logic          m_valid, m_ovf;

  ofifo_hs #(.col(COL), .psum_bw(PB), .depth(DEP), .afull_th(ATH)) dut (
    .clk(clk), .reset(reset), .clr(clr), .in(in), .wr(wr), .rd(rd),
    .out(out), .o_valid(o_valid), .o_ready(o_ready), .o_full(o_full),
    .o_almost_full(o_almost_full), .o_level(o_level), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  function automatic void model_reset(input bit keep_out);
    for (int i = 0; i < COL; i++) mq[i].delete();
    if (!keep_out) m_out = '0;
    m_valid = 0;
    m_ovf = 0;
  endfunction

  function automatic int m_level();
    int m = DEP;
    for (int i = 0; i < COL; i++) if (mq[i].size() < m) m = mq[i].size();
    return m;
  endfunction

  function automatic void model_step(input logic [COL-1:0] w, input logic [W-1:0] d,
                                     input logic r, input logic c);
    bit avail = 1;
    bit fl [COL];
    if (c) begin
      model_reset(1);
      return;
    end
    for (int i = 0; i < COL; i++) begin
      if (mq[i].size() == 0) avail = 0;
      fl[i] = (mq[i].size() == DEP);
    end
    if (avail && (!m_valid || r)) begin
      for (int i = 0; i < COL; i++) m_out[i*PB +: PB] = mq[i].pop_front();
      m_valid = 1;
    end else if (r) m_valid = 0;
    for (int i = 0; i < COL; i++)
      if (w[i]) begin
        if (fl[i]) m_ovf = 1;
        else mq[i].push_back(d[i*PB +: PB]);
      end
  endfunction

  task automatic cyc(input logic [COL-1:0] w, input logic [W-1:0] d, input logic r, input logic c);
    wr = w; in = d; rd = r; clr = c;
    @(posedge clk);
    model_step(w, d, r, c);
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] v;
    for (int i = 0; i < COL; i++) v[i*PB +: PB] = PB'($urandom);
    return v;
  endfunction

  task automatic test_reset();
    reset = 1;
    #1;
    model_reset(0);
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", o_valid); end
    n_chk++; if (out !== '0) begin n_fail++; $display("FAIL reset_out got %h want 0", out); end
    n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", o_ready); end
    n_chk++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b want 0", o_full); end
    n_chk++; if (o_almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull got %0b want 0", o_almost_full); end
    n_chk++; if (o_level !== '0) begin n_fail++; $display("FAIL reset_level got %0d want 0", o_level); end
    n_chk++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", o_overflow); end
    @(negedge clk); reset = 0;
    @(negedge clk);
  endtask

  task automatic test_single_row();
    logic [W-1:0] d;
    for (int i = 0; i < COL; i++) d[i*PB +: PB] = PB'(i + 1);
    cyc('1, d, 1, 0);
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid1 got %0b want 0", o_valid); end
    n_chk++; if (o_level !== LW'(1)) begin n_fail++; $display("FAIL single_level1 got %0d want 1", o_level); end
    cyc('0, '0, 1, 0);
    n_chk++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid2 got %0b want 1", o_valid); end
    n_chk++; if (out !== d) begin n_fail++; $display("FAIL single_out got %h want %h", out, d); end
    n_chk++; if (o_level !== '0) begin n_fail++; $display("FAIL single_level2 got %0d want 0", o_level); end
  endtask

  task automatic test_skew();
    logic [W-1:0] row = '0, d;
    cyc('0, '0, 1, 1);
    for (int t = 0; t < COL; t++) begin
      d = rand_row();
      row[t*PB +: PB] = d[t*PB +: PB];
      cyc(COL'(1) << t, d, 1, 0);
      n_chk++; if (o_level !== LW'(t == COL-1)) begin n_fail++; $display("FAIL skew_level t=%0d got %0d want %0d", t, o_level, t == COL-1); end
      n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL skew_valid t=%0d got %0b want 0", t, o_valid); end
    end
    cyc('0, '0, 1, 0);
    n_chk++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL skew_valid_out got %0b want 1", o_valid); end
    n_chk++; if (out !== row) begin n_fail++; $display("FAIL skew_out got %h want %h", out, row); end
    cyc('0, '0, 1, 0);
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL skew_drain got %0b want 0", o_valid); end
  endtask

  task automatic test_fill();
    int exp_lvl;
    cyc('0, '0, 0, 1);
    for (int n = 1; n <= DEP + 1; n++) begin
      cyc('1, rand_row(), 0, 0);
      exp_lvl = (n == 1) ? 1 : n - 1;
      n_chk++; if (o_level !== LW'(exp_lvl)) begin n_fail++; $display("FAIL fill_level n=%0d got %0d want %0d", n, o_level, exp_lvl); end
      n_chk++; if (o_almost_full !== (exp_lvl >= ATH)) begin n_fail++; $display("FAIL fill_afull n=%0d got %0b want %0b", n, o_almost_full, exp_lvl >= ATH); end
      n_chk++; if (o_full !== (exp_lvl == DEP)) begin n_fail++; $display("FAIL fill_full n=%0d got %0b want %0b", n, o_full, exp_lvl == DEP); end
      n_chk++; if (o_ready !== (exp_lvl != DEP)) begin n_fail++; $display("FAIL fill_ready n=%0d got %0b want %0b", n, o_ready, exp_lvl != DEP); end
    end
    n_chk++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL fill_valid got %0b want 1", o_valid); end
  endtask

  task automatic test_overflow();
    int guard = 0;
    cyc(COL'(1) << 3, rand_row(), 1, 0);
    n_chk++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b want 1", o_overflow); end
    n_chk++; if (o_level !== LW'(DEP-1)) begin n_fail++; $display("FAIL ovf_level got %0d want %0d", o_level, DEP-1); end
    n_chk++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL ovf_full got %0b want 0", o_full); end
    while ((m_valid || m_level() > 0) && guard < 200) begin
      cyc('0, '0, 1, 0);
      guard++;
      n_chk++; if (o_valid !== m_valid) begin n_fail++; $display("FAIL drain_valid got %0b want %0b", o_valid, m_valid); end
      if (m_valid) begin
        n_chk++; if (out !== m_out) begin n_fail++; $display("FAIL drain_out got %h want %h", out, m_out); end
      end
    end
    n_chk++; if (guard >= 200) begin n_fail++; $display("FAIL drain_timeout got %0d want <200", guard); end
    n_chk++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0b want 1", o_overflow); end
  endtask

  task automatic test_rd_toggle();
    int rows = 0, cycles = 0;
    logic [COL-1:0] w;
    logic [W-1:0] prev_out;
    logic prev_valid, r;
    cyc('0, '0, 0, 1);
    while (rows < 100 && cycles < 3000) begin
      r = cycles[0];
      w = COL'($urandom);
      for (int i = 0; i < COL; i++) if (mq[i].size() >= DEP - 2) w[i] = 0;
      prev_out = out; prev_valid = o_valid;
      if (m_valid && r) rows++;
      cyc(w, rand_row(), r, 0);
      cycles++;
      n_chk++; if (o_valid !== m_valid) begin n_fail++; $display("FAIL tog_valid c=%0d got %0b want %0b", cycles, o_valid, m_valid); end
      n_chk++; if (o_level !== LW'(m_level())) begin n_fail++; $display("FAIL tog_level c=%0d got %0d want %0d", cycles, o_level, m_level()); end
      if (m_valid) begin
        n_chk++; if (out !== m_out) begin n_fail++; $display("FAIL tog_out c=%0d got %h want %h", cycles, out, m_out); end
      end
      if (prev_valid && !r) begin
        n_chk++; if (out !== prev_out) begin n_fail++; $display("FAIL tog_stall c=%0d got %h want %h", cycles, out, prev_out); end
      end
    end
    n_chk++; if (rows < 100) begin n_fail++; $display("FAIL tog_timeout rows got %0d want 100", rows); end
    n_chk++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL tog_ovf got %0b want 0", o_overflow); end
  endtask

  task automatic test_clr();
    logic [W-1:0] held;
    cyc('0, '0, 0, 1);
    for (int n = 0; n < 11; n++) cyc('1, rand_row(), 0, 0);
    n_chk++; if (o_level !== LW'(10)) begin n_fail++; $display("FAIL clr_pre_level got %0d want 10", o_level); end
    held = out;
    cyc('1, rand_row(), 1, 1);
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid got %0b want 0", o_valid); end
    n_chk++; if (o_level !== '0) begin n_fail++; $display("FAIL clr_level got %0d want 0", o_level); end
    n_chk++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got %0b want 0", o_overflow); end
    n_chk++; if (out !== held) begin n_fail++; $display("FAIL clr_out_hold got %h want %h", out, held); end
    cyc('0, '0, 1, 0);
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL clr_ignored_wr got %0b want 0", o_valid); end
    for (int n = 0; n < 5; n++) cyc('1, rand_row(), 0, 0);
    wr = '1; in = rand_row(); rd = 0;
    #2 reset = 1;
    #1;
    model_reset(0);
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %0b want 0", o_valid); end
    n_chk++; if (o_level !== '0) begin n_fail++; $display("FAIL rst_mid_level got %0d want 0", o_level); end
    n_chk++; if (out !== '0) begin n_fail++; $display("FAIL rst_mid_out got %h want 0", out); end
    n_chk++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ovf got %0b want 0", o_overflow); end
    @(negedge clk); reset = 0; wr = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_skew();
    test_fill();
    test_overflow();
    test_rd_toggle();
    test_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
